wb_port_arbiter: RTL and testbench

Write-back port arbiter for the register file. Shares the single register-file write port between the ALU result stream, which comes out of the ALU pipeline register, and the load-return stream from data memory. Load returns cannot be held, so they always win. ALU writes that lose arbitration go into a small in-order skid FIFO, and the ALU pipeline is back-pressured only when that FIFO is full. A lookup port lets decode forward values that are still waiting for write-back.

---
 rtl/wb_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-back arbiter: load returns always win, losing ALU writes queue in an in-order skid FIFO.
// Latency: 1 cycle from input to rf_we; a buffered ALU write waits 1 cycle per entry ahead plus 1 per intervening load.
// Backpressure: alu_stall is high while the FIFO is full (registered state only); loads are never stalled.
// Optional WB_TRACE_EN adds registered trace_* outputs that mirror each register-file write and its source.
module wb_port_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 6,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_we_in,
    input  logic [SEL_W-1:0]  alu_rd_in,
    input  logic [DATA_W-1:0] alu_result_in,
    output logic              alu_stall,
    input  logic              ld_valid,
    input  logic [SEL_W-1:0]  ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rf_we,
    output logic [SEL_W-1:0]  rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [CNT_W-1:0]  pending_count,
    input  logic [SEL_W-1:0]  rs_sel,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`ifdef WB_TRACE_EN
    ,
    output logic              trace_valid,
    output logic [SEL_W-1:0]  trace_rd,
    output logic [DATA_W-1:0] trace_data,
    output logic              trace_src
`endif
);

    // Skid FIFO storage; only entries below pending_count are meaningful.
    logic [SEL_W-1:0]  q_rd   [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic              alu_acc;
    logic              alu_nz;
    logic              ld_eff;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic              out_we_nxt;
    logic [SEL_W-1:0]  out_rd_nxt;
    logic [DATA_W-1:0] out_data_nxt;
    logic              out_src_nxt;

    // Stall depends only on the occupancy register, so no input reaches it combinationally.
    assign alu_stall  = (pending_count == CNT_W'(DEPTH));
    assign fifo_empty = (pending_count == '0);
    assign alu_acc    = alu_we_in & ~alu_stall;
    // x0 requests are accepted but never stored or written.
    assign alu_nz     = alu_acc & (alu_rd_in != '0);
    assign ld_eff     = ld_valid & (ld_rd != '0);
    assign push       = alu_nz & (ld_eff | ~fifo_empty);
    assign pop        = ~ld_eff & ~fifo_empty;

    // Output-stage source select: load, then FIFO head, then ALU bypass.
    always_comb begin
        out_we_nxt   = 1'b0;
        out_rd_nxt   = rf_rd;
        out_data_nxt = rf_wdata;
        out_src_nxt  = 1'b0;
        if (ld_eff) begin
            out_we_nxt   = 1'b1;
            out_rd_nxt   = ld_rd;
            out_data_nxt = ld_data;
            out_src_nxt  = 1'b1;
        end else if (!fifo_empty) begin
            out_we_nxt   = 1'b1;
            out_rd_nxt   = q_rd[head];
            out_data_nxt = q_data[head];
        end else if (alu_nz) begin
            out_we_nxt   = 1'b1;
            out_rd_nxt   = alu_rd_in;
            out_data_nxt = alu_result_in;
        end
    end

    // Output register; select and data hold their last values on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= out_we_nxt;
            if (out_we_nxt) begin
                rf_rd    <= out_rd_nxt;
                rf_wdata <= out_data_nxt;
            end
        end
    end

    // FIFO pointers and occupancy; push at full cannot happen because acceptance is stall-gated.
    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            pending_count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)
                pending_count <= pending_count + CNT_W'(1);
            else if (pop && !push)
                pending_count <= pending_count - CNT_W'(1);
        end
    end

    // FIFO payload storage needs no reset; validity comes from pending_count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]   <= alu_rd_in;
            q_data[tail] <= alu_result_in;
        end
    end

    // Forwarding lookup: scan oldest to newest so the newest matching value wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (rs_sel != '0) begin
            if (rf_we && (rf_rd == rs_sel)) begin
                fwd_hit  = 1'b1;
                fwd_data = rf_wdata;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PTR_W'(i);
                if ((CNT_W'(i) < pending_count) && (q_rd[idx] == rs_sel)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = q_data[idx];
                end
            end
        end
    end

`ifdef WB_TRACE_EN
    // Trace mirror of each register-file write, updated on the same edges as rf_*.
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid <= 1'b0;
            trace_rd    <= '0;
            trace_data  <= '0;
            trace_src   <= 1'b0;
        end else begin
            trace_valid <= out_we_nxt;
            if (out_we_nxt) begin
                trace_rd   <= out_rd_nxt;
                trace_data <= out_data_nxt;
                trace_src  <= out_src_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2): per-cycle vector table plus a queued-drain sequence.
// Inputs change at the falling edge; outputs are compared at the next falling edge.
// Every vector and hand check counts as one comparison in the summary.
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 6;
    localparam int NV     = 23;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_we_in;
    logic [SEL_W-1:0]  alu_rd_in;
    logic [DATA_W-1:0] alu_result_in;
    logic              alu_stall;
    logic              ld_valid;
    logic [SEL_W-1:0]  ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic              rf_we;
    logic [SEL_W-1:0]  rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic [1:0]        pending_count;
    logic [SEL_W-1:0]  rs_sel;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(2), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .alu_we_in(alu_we_in), .alu_rd_in(alu_rd_in), .alu_result_in(alu_result_in),
        .alu_stall(alu_stall),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .pending_count(pending_count),
        .rs_sel(rs_sel), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    typedef struct {
        logic              rst;
        logic              aw;
        logic [SEL_W-1:0]  ard;
        logic [DATA_W-1:0] ares;
        logic              lv;
        logic [SEL_W-1:0]  lrd;
        logic [DATA_W-1:0] ldat;
        logic [SEL_W-1:0]  rs;
        logic              e_we;
        logic [SEL_W-1:0]  e_rd;
        logic [DATA_W-1:0] e_wd;
        logic [1:0]        e_cnt;
        logic              e_stall;
        logic              e_hit;
        logic [DATA_W-1:0] e_fd;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic aw, input int ard, input int ares,
                                input logic lv, input int lrd, input int ldat, input int rs,
                                input logic we, input int rd, input int wd, input int cnt,
                                input logic st, input logic hit, input int fd);
        vec_t v;
        v.rst = r;  v.aw = aw; v.ard = SEL_W'(ard); v.ares = DATA_W'(ares);
        v.lv = lv;  v.lrd = SEL_W'(lrd); v.ldat = DATA_W'(ldat); v.rs = SEL_W'(rs);
        v.e_we = we; v.e_rd = SEL_W'(rd); v.e_wd = DATA_W'(wd); v.e_cnt = 2'(cnt);
        v.e_stall = st; v.e_hit = hit; v.e_fd = DATA_W'(fd);
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        rst = v.rst; alu_we_in = v.aw; alu_rd_in = v.ard; alu_result_in = v.ares;
        ld_valid = v.lv; ld_rd = v.lrd; ld_data = v.ldat; rs_sel = v.rs;
    endtask

    task automatic set_idle();
        rst = 1'b0; alu_we_in = 1'b0; alu_rd_in = '0; alu_result_in = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0; rs_sel = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit found;
        bit seen14;
        //                rst aw ard ares  lv lrd ldat  rs | we rd wd    cnt st hit fd
        vecs[0]  = mk(1, 0, 0, 0,     0, 0,  0,    0,   0, 0,  0,    0, 0, 0, 0);
        // ALU only, bypass
        vecs[1]  = mk(0, 1, 5, 'h11,  0, 0,  0,    5,   1, 5,  'h11, 0, 0, 1, 'h11);
        // collision: load wins, ALU queued
        vecs[2]  = mk(0, 1, 3, 'h33,  1, 7,  'hAA, 3,   1, 7,  'hAA, 1, 0, 1, 'h33);
        vecs[3]  = mk(0, 0, 0, 0,     0, 0,  0,    7,   1, 3,  'h33, 0, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0,     0, 0,  0,    3,   0, 3,  'h33, 0, 0, 0, 0);
        // full: three loads, ALU r1,r2 queued, r3 held by stall
        vecs[5]  = mk(0, 1, 1, 'h1,   1, 10, 'hA0, 0,   1, 10, 'hA0, 1, 0, 0, 0);
        vecs[6]  = mk(0, 1, 2, 'h2,   1, 11, 'hA1, 1,   1, 11, 'hA1, 2, 1, 1, 'h1);
        vecs[7]  = mk(0, 1, 3, 'h3,   1, 12, 'hA2, 3,   1, 12, 'hA2, 2, 1, 0, 0);
        vecs[8]  = mk(0, 1, 3, 'h3,   0, 0,  0,    2,   1, 1,  'h1,  1, 0, 1, 'h2);
        vecs[9]  = mk(0, 1, 3, 'h3,   0, 0,  0,    3,   1, 2,  'h2,  1, 0, 1, 'h3);
        vecs[10] = mk(0, 0, 0, 0,     0, 0,  0,    3,   1, 3,  'h3,  0, 0, 1, 'h3);
        vecs[11] = mk(0, 0, 0, 0,     0, 0,  0,    3,   0, 3,  'h3,  0, 0, 0, 0);
        // x0 drops
        vecs[12] = mk(0, 1, 0, 'hFF,  0, 0,  0,    0,   0, 3,  'h3,  0, 0, 0, 0);
        vecs[13] = mk(0, 1, 0, 'hFF,  1, 0,  'hEE, 0,   0, 3,  'h3,  0, 0, 0, 0);
        vecs[14] = mk(0, 1, 9, 'h99,  1, 8,  'h80, 9,   1, 8,  'h80, 1, 0, 1, 'h99);
        vecs[15] = mk(0, 0, 0, 0,     1, 0,  'h55, 0,   1, 9,  'h99, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 0, 0,     0, 0,  0,    9,   0, 9,  'h99, 0, 0, 0, 0);
        // forwarding: newest of two r3 entries
        vecs[17] = mk(0, 1, 3, 'h33,  1, 20, 'hC0, 3,   1, 20, 'hC0, 1, 0, 1, 'h33);
        vecs[18] = mk(0, 1, 3, 'h44,  1, 21, 'hC1, 3,   1, 21, 'hC1, 2, 1, 1, 'h44);
        vecs[19] = mk(0, 0, 0, 0,     1, 22, 'hC2, 4,   1, 22, 'hC2, 2, 1, 0, 0);
        // reset with two entries pending: nothing written afterwards
        vecs[20] = mk(1, 0, 0, 0,     0, 0,  0,    3,   0, 0,  0,    0, 0, 0, 0);
        vecs[21] = mk(0, 0, 0, 0,     0, 0,  0,    3,   0, 0,  0,    0, 0, 0, 0);
        vecs[22] = mk(0, 0, 0, 0,     0, 0,  0,    3,   0, 0,  0,    0, 0, 0, 0);

        set_idle();
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i]);
            tick();
            n_vec++;
            if ({rf_we, rf_rd, rf_wdata, pending_count, alu_stall, fwd_hit, fwd_data} !==
                {vecs[i].e_we, vecs[i].e_rd, vecs[i].e_wd, vecs[i].e_cnt,
                 vecs[i].e_stall, vecs[i].e_hit, vecs[i].e_fd}) begin
                n_bad++;
                $display("FAIL vec%0d: got we=%0d rd=%0d wd=%h cnt=%0d stall=%0d hit=%0d fd=%h; want we=%0d rd=%0d wd=%h cnt=%0d stall=%0d hit=%0d fd=%h",
                         i, rf_we, rf_rd, rf_wdata, pending_count, alu_stall, fwd_hit, fwd_data,
                         vecs[i].e_we, vecs[i].e_rd, vecs[i].e_wd, vecs[i].e_cnt,
                         vecs[i].e_stall, vecs[i].e_hit, vecs[i].e_fd);
            end
        end

        // Two ALU writes queued behind loads, then drained in order within a bounded wait.
        set_idle();
        ld_valid = 1'b1; ld_rd = 6'd30; ld_data = 32'h1;
        alu_we_in = 1'b1; alu_rd_in = 6'd14; alu_result_in = 32'hE1;
        tick();
        ld_rd = 6'd31; ld_data = 32'h2;
        alu_rd_in = 6'd15; alu_result_in = 32'hE2;
        tick();
        n_vec++;
        if (!(alu_stall === 1'b1 && pending_count === 2'd2)) begin
            n_bad++;
            $display("FAIL fill: got stall=%0d cnt=%0d; want stall=1 cnt=2", alu_stall, pending_count);
        end
        set_idle();
        found  = 1'b0;
        seen14 = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            tick();
            if (rf_we && rf_rd == 6'd14 && rf_wdata == 32'hE1) seen14 = 1'b1;
            if (rf_we && rf_rd == 6'd15) found = 1'b1;
        end
        n_vec++;
        if (!(found && seen14 && rf_wdata === 32'hE2 && pending_count === 2'd0)) begin
            n_bad++;
            $display("FAIL drain: got found=%0d seen14=%0d wd=%h cnt=%0d; want found=1 seen14=1 wd=e2 cnt=0",
                     found, seen14, rf_wdata, pending_count);
        end
        tick();
        n_vec++;
        if (!(rf_we === 1'b0 && alu_stall === 1'b0 && rf_rd === 6'd15)) begin
            n_bad++;
            $display("FAIL idle_after_drain: got we=%0d stall=%0d rd=%0d; want we=0 stall=0 rd=15",
                     rf_we, alu_stall, rf_rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
